// File: rtl/mmio_seg_ctrl.sv
// MMIO controller on the MEM-stage data bus: decodes 0xFFFFFF00-0xFFFFFFFF as peripheral
// registers (7-segment scan, LEDs, switches, cycle counter) and passes all else to dmem.
module mmio_seg_ctrl #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   input  logic [31:0] dmem_rd,
   input  logic [15:0] sw,
   output logic        dmem_we,
   output logic [31:0] rd,
   output logic [15:0] led,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

   localparam logic [5:0] OFF_SEG_DATA = 6'h00;
   localparam logic [5:0] OFF_LED      = 6'h01;
   localparam logic [5:0] OFF_SW       = 6'h02;
   localparam logic [5:0] OFF_CYCLE    = 6'h03;
   localparam logic [5:0] OFF_SEG_CTRL = 6'h04;

   // Active-low gfedcba pattern for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         4'hF:    s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   logic [31:0]      r_seg_data;
   logic [15:0]      r_led;
   logic             r_en;
   logic [7:0]       r_dp_mask;
   logic [31:0]      r_cycle;
   logic [15:0]      r_sw_meta;
   logic [15:0]      r_sw_sync;
   logic [DIV_W-1:0] r_div;
   logic [2:0]       r_idx;
   logic [7:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;

   logic        w_mmio;
   logic [5:0]  w_off;
   logic        w_mmio_wr;
   logic [3:0]  w_nibble;
   logic [31:0] w_reg_rd;
   logic        w_unused;

   assign w_mmio    = (a[31:8] == 24'hFFFFFF);
   assign w_off     = a[7:2];
   assign w_mmio_wr = we & w_mmio;
   assign w_unused  = &{1'b0, a[1:0]};
   assign dmem_we   = we & ~w_mmio;
   assign w_nibble  = r_seg_data[{r_idx, 2'b00} +: 4];

   // Peripheral register read mux; unmapped offsets read zero.
   always_comb begin
      w_reg_rd = 32'h0000_0000;
      case (w_off)
         OFF_SEG_DATA: w_reg_rd = r_seg_data;
         OFF_LED:      w_reg_rd = {16'h0000, r_led};
         OFF_SW:       w_reg_rd = {16'h0000, r_sw_sync};
         OFF_CYCLE:    w_reg_rd = r_cycle;
         OFF_SEG_CTRL: w_reg_rd = {16'h0000, r_dp_mask, 7'b000_0000, r_en};
         default:      w_reg_rd = 32'h0000_0000;
      endcase
   end

   assign rd = w_mmio ? w_reg_rd : dmem_rd;

   // Software-writable configuration registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg_data <= 32'h0000_0000;
         r_led      <= 16'h0000;
         r_en       <= 1'b0;
         r_dp_mask  <= 8'h00;
      end else if (w_mmio_wr) begin
         case (w_off)
            OFF_SEG_DATA: r_seg_data <= wd;
            OFF_LED:      r_led      <= wd[15:0];
            OFF_SEG_CTRL: begin
               r_en      <= wd[0];
               r_dp_mask <= wd[15:8];
            end
            default: ;
         endcase
      end
   end

   // Free-running cycle counter; a store to CYCLE overrides the increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle <= 32'h0000_0000;
      end else if (w_mmio_wr && (w_off == OFF_CYCLE)) begin
         r_cycle <= 32'h0000_0000;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   // Two-flop synchroniser for the asynchronous switch inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sw_meta <= 16'h0000;
         r_sw_sync <= 16'h0000;
      end else begin
         r_sw_meta <= sw;
         r_sw_sync <= r_sw_meta;
      end
   end

   // Digit scan divider; disabling parks the scan on digit 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div <= '0;
         r_idx <= 3'd0;
      end else if (!r_en) begin
         r_div <= '0;
         r_idx <= 3'd0;
      end else if (r_div == DIV_MAX) begin
         r_div <= '0;
         r_idx <= r_idx + 3'd1;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Registered display drive, blanked while disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_an  <= 8'hFF;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else if (r_en) begin
         r_an  <= ~(8'b0000_0001 << r_idx);
         r_seg <= hex7(w_nibble);
         r_dp  <= ~r_dp_mask[r_idx];
      end else begin
         r_an  <= 8'hFF;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end
   end

   assign led = r_led;
   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule

// File: tb/tb_mmio_seg_ctrl.sv
// Directed self-checking bench for mmio_seg_ctrl with SCAN_DIV = 4.
module tb_mmio_seg_ctrl;

   logic        clk;
   logic        reset;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] dmem_rd;
   logic [15:0] sw;
   logic        dmem_we;
   logic [31:0] rd;
   logic [15:0] led;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [6:0] HEX_TAB [8] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                          7'h19, 7'h12, 7'h02, 7'h78};

   mmio_seg_ctrl #(.SCAN_DIV(4)) dut (
      .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .dmem_rd(dmem_rd),
      .sw(sw), .dmem_we(dmem_we), .rd(rd), .led(led), .an(an), .seg(seg), .dp(dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      we = 1'b1; a = addr; wd = data;
      @(posedge clk);
      #1;
      we = 1'b0; a = 32'h0000_0000; wd = 32'h0000_0000;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      a = addr;
      #1;
      data = rd;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      bus_write(32'hFFFF_FF04, 32'h0000_00FF);
      bus_write(32'hFFFF_FF00, 32'h1234_5678);
      bus_write(32'hFFFF_FF10, 32'h0000_FF01);
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (an === 8'hFF) begin
         n_fail++; $display("FAIL reset_pre_an got %h required lit digit", an);
      end
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (an !== 8'hFF) begin n_fail++; $display("FAIL reset_an got %h required ff", an); end
      n_tests++;
      if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h required 7f", seg); end
      n_tests++;
      if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b required 1", dp); end
      n_tests++;
      if (led !== 16'h0000) begin n_fail++; $display("FAIL reset_led got %h required 0000", led); end
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: a = 32'hFFFF_FF00;
            1: a = 32'hFFFF_FF04;
            2: a = 32'hFFFF_FF0C;
            default: a = 32'hFFFF_FF10;
         endcase
         #1;
         v = rd;
         n_tests++;
         if (v !== 32'h0000_0000) begin
            n_fail++; $display("FAIL reset_read addr %h got %h required 0", a, v);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      a = 32'h0000_0000;
   endtask

   task automatic test_bus_routing();
      logic [31:0] v;
      @(negedge clk);
      we = 1'b1; a = 32'h0000_0010; wd = 32'h0001_A5A5;
      #1;
      n_tests++;
      if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL dmem_we_ram got %b required 1", dmem_we); end
      @(negedge clk);
      a = 32'hFFFF_FF04;
      #1;
      n_tests++;
      if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL dmem_we_mmio got %b required 0", dmem_we); end
      n_tests++;
      if (rd !== 32'h0000_0000) begin
         n_fail++; $display("FAIL same_cycle_old got %h required 0", rd);
      end
      @(posedge clk);
      #1;
      we = 1'b0;
      n_tests++;
      if (led !== 16'hA5A5) begin n_fail++; $display("FAIL led_drive got %h required a5a5", led); end
      bus_read(32'hFFFF_FF04, v);
      n_tests++;
      if (v !== 32'h0000_A5A5) begin n_fail++; $display("FAIL led_read got %h required 0000a5a5", v); end
      dmem_rd = 32'h0000_1234;
      bus_read(32'h0000_0010, v);
      n_tests++;
      if (v !== 32'h0000_1234) begin n_fail++; $display("FAIL dmem_read got %h required 00001234", v); end
      dmem_rd = 32'hCAFE_0001;
      bus_read(32'hFFFF_FEFC, v);
      n_tests++;
      if (v !== 32'hCAFE_0001) begin n_fail++; $display("FAIL boundary_read got %h required cafe0001", v); end
      we = 1'b1;
      #1;
      n_tests++;
      if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL boundary_we got %b required 1", dmem_we); end
      we = 1'b0;
      dmem_rd = 32'h0000_0000;
   endtask

   task automatic test_scan();
      logic [2:0] di;
      logic [7:0] exp_an;
      bus_write(32'hFFFF_FF00, 32'h7654_3210);
      bus_write(32'hFFFF_FF10, 32'h0000_0201);
      for (int d = 0; d < 9; d++) begin
         di = 3'(d % 8);
         exp_an = ~(8'b0000_0001 << di);
         for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (an !== exp_an || seg !== HEX_TAB[di] || dp !== (di != 3'd1)) begin
               n_fail++;
               $display("FAIL scan d%0d c%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                        d, c, an, seg, dp, exp_an, HEX_TAB[di], (di != 3'd1));
            end
         end
      end
   endtask

   task automatic test_disable();
      bit found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk);
         #1;
         if (an === 8'hDF) found = 1'b1;
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL wait_digit5 got %h required df", an); end
      bus_write(32'hFFFF_FF10, 32'h0000_0000);
      @(posedge clk);
      #1;
      n_tests++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
         n_fail++; $display("FAIL disable got an=%h seg=%h dp=%b required ff 7f 1", an, seg, dp);
      end
      bus_write(32'hFFFF_FF10, 32'h0000_0001);
      @(posedge clk);
      #1;
      n_tests++;
      if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
         n_fail++; $display("FAIL reenable got an=%h seg=%h dp=%b required fe 40 1", an, seg, dp);
      end
   endtask

   task automatic test_cycle();
      bus_write(32'hFFFF_FF0C, 32'hDEAD_BEEF);
      a = 32'hFFFF_FF0C;
      @(posedge clk);
      #1;
      n_tests++;
      if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL cycle_n1 got %h required 1", rd); end
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (rd !== 32'h0000_0005) begin n_fail++; $display("FAIL cycle_n5 got %h required 5", rd); end
      @(negedge clk);
      force dut.r_cycle = 32'hFFFF_FFFF;
      #1;
      n_tests++;
      if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_max got %h required ffffffff", rd); end
      release dut.r_cycle;
      @(posedge clk);
      #1;
      n_tests++;
      if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL cycle_wrap got %h required 0", rd); end
      a = 32'h0000_0000;
   endtask

   task automatic test_sw_and_unmapped();
      logic [31:0] v;
      @(negedge clk);
      sw = 16'hBEEF;
      a = 32'hFFFF_FF08;
      #1;
      n_tests++;
      if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL sw_c0 got %h required 0", rd); end
      @(posedge clk);
      #1;
      n_tests++;
      if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL sw_c1 got %h required 0", rd); end
      @(posedge clk);
      #1;
      n_tests++;
      if (rd !== 32'h0000_BEEF) begin n_fail++; $display("FAIL sw_c2 got %h required 0000beef", rd); end
      bus_write(32'hFFFF_FF14, 32'hFFFF_FFFF);
      bus_read(32'hFFFF_FF14, v);
      n_tests++;
      if (v !== 32'h0000_0000) begin n_fail++; $display("FAIL unmapped_read got %h required 0", v); end
      bus_read(32'hFFFF_FF00, v);
      n_tests++;
      if (v !== 32'h7654_3210) begin n_fail++; $display("FAIL unmapped_segdata got %h required 76543210", v); end
      bus_read(32'hFFFF_FF04, v);
      n_tests++;
      if (v !== 32'h0000_A5A5) begin n_fail++; $display("FAIL unmapped_led got %h required 0000a5a5", v); end
      bus_read(32'hFFFF_FF12, v);
      n_tests++;
      if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL unmapped_segctrl got %h required 00000001", v); end
      a = 32'h0000_0000;
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; a = 32'h0000_0000; wd = 32'h0000_0000;
      dmem_rd = 32'h0000_0000; sw = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_bus_routing();
      test_scan();
      test_disable();
      test_cycle();
      test_sw_and_unmapped();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
